// File: rtl/serdes_pkg.sv
// Shared encodings for the serial link transmitter and receiver.
package serdes_pkg;

  typedef enum logic {
    ST_HUNT = 1'b0,
    ST_RECV = 1'b1
  } state_t;

  localparam logic ORD_MSB = 1'b0;
  localparam logic ORD_LSB = 1'b1;

endpackage

// File: rtl/serial_word_deser_if.sv
// Serial input, parallel valid/ready output and error-flag bundle of the word deserializer.
interface serial_word_deser_if #(parameter int WIDTH = 4);
  import serdes_pkg::*;

  logic             sin;
  logic             sin_valid;
  logic             sync;
  logic             lsb_first;
  logic [WIDTH-1:0] q;
  logic             out_valid;
  logic             out_ready;
  logic             busy;
  logic             frame_err;
  logic             overrun;
  logic             err_clr;

  modport master (
    output sin, sin_valid, sync, lsb_first, out_ready, err_clr,
    input  q, out_valid, busy, frame_err, overrun
  );

  modport slave (
    input  sin, sin_valid, sync, lsb_first, out_ready, err_clr,
    output q, out_valid, busy, frame_err, overrun
  );

endinterface

// File: rtl/deser_shift_core.sv
// Bidirectional shift-in register with bit counter; word is the value sreg takes on this edge,
// last_bit flags the edge that shifts in the final bit of a word. No backpressure.
module deser_shift_core
  import serdes_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             shift_en,
  input  logic             restart,
  input  logic             order,
  input  logic             sin,
  output logic [WIDTH-1:0] word,
  output logic             last_bit
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [WIDTH-1:0] sreg;
  logic [CW-1:0]    cnt;

  always_comb begin
    word = (order == ORD_LSB) ? {sin, sreg[WIDTH-1:1]} : {sreg[WIDTH-2:0], sin};
  end

  // A restart always begins a fresh word, so it can never be the last bit (WIDTH >= 2).
  assign last_bit = shift_en && !restart && (cnt == LAST);

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      sreg <= '0;
      cnt  <= '0;
    end else if (shift_en) begin
      sreg <= word;
      if (restart)       cnt <= CW'(1);
      else if (last_bit) cnt <= '0;
      else               cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/serial_word_deser.sv
// Serial-to-parallel receiver: q/out_valid update 1 cycle after the last bit of a word.
// A word completing while out_valid is held without out_ready is dropped and flags overrun.
module serial_word_deser
  import serdes_pkg::*;
#(
  parameter int WIDTH        = 4,
  parameter int REQUIRE_SYNC = 1
) (
  input logic                clk,
  input logic                clr,
  serial_word_deser_if.slave bus
);

  state_t           state_q, state_d;
  logic             order_q;
  logic             shift_en, restart, eff_order;
  logic             last_bit;
  logic [WIDTH-1:0] word;
  logic [WIDTH-1:0] q_r;
  logic             vld_r, frame_r, ovr_r;
  logic             frame_set, ovr_set;

  // Input decode; a sync bit always starts a new word and re-latches the bit order.
  always_comb begin
    shift_en  = 1'b0;
    restart   = 1'b0;
    frame_set = 1'b0;
    eff_order = order_q;
    if (bus.sin_valid) begin
      restart   = bus.sync;
      shift_en  = bus.sync || (state_q == ST_RECV);
      frame_set = bus.sync && (state_q == ST_RECV);
      if (bus.sync) eff_order = bus.lsb_first;
    end
  end

  deser_shift_core #(.WIDTH(WIDTH)) u_core (
    .clk      (clk),
    .clr      (clr),
    .shift_en (shift_en),
    .restart  (restart),
    .order    (eff_order),
    .sin      (bus.sin),
    .word     (word),
    .last_bit (last_bit)
  );

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= ST_HUNT;
      order_q <= ORD_MSB;
    end else begin
      state_q <= state_d;
      if (restart) order_q <= bus.lsb_first;
    end
  end

  always_comb begin
    state_d = state_q;
    ovr_set = 1'b0;
    if (shift_en) begin
      if (last_bit) state_d = (REQUIRE_SYNC != 0) ? ST_HUNT : ST_RECV;
      else          state_d = ST_RECV;
    end
    if (last_bit && vld_r && !bus.out_ready) ovr_set = 1'b1;
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      q_r   <= '0;
      vld_r <= 1'b0;
    end else if (last_bit) begin
      if (!vld_r || bus.out_ready) begin
        q_r   <= word;
        vld_r <= 1'b1;
      end
    end else if (vld_r && bus.out_ready) begin
      vld_r <= 1'b0;
    end
  end

  // Sticky flags: a set event on the same edge as err_clr takes priority.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      frame_r <= 1'b0;
      ovr_r   <= 1'b0;
    end else begin
      if (frame_set)        frame_r <= 1'b1;
      else if (bus.err_clr) frame_r <= 1'b0;
      if (ovr_set)          ovr_r   <= 1'b1;
      else if (bus.err_clr) ovr_r   <= 1'b0;
    end
  end

  assign bus.q         = q_r;
  assign bus.out_valid = vld_r;
  assign bus.busy      = (state_q == ST_RECV);
  assign bus.frame_err = frame_r;
  assign bus.overrun   = ovr_r;

endmodule

// File: tb/tb_serial_word_deser.sv
// Directed bench for serial_word_deser: dut_a requires sync per word, dut_b runs words back-to-back.
module tb_serial_word_deser;

  logic clk;
  logic clr;
  int   total;
  int   bad;

  logic [3:0] qa[$];
  logic [3:0] qb[$];

  serial_word_deser_if #(.WIDTH(4)) ifa ();
  serial_word_deser_if #(.WIDTH(4)) ifb ();

  serial_word_deser #(.WIDTH(4), .REQUIRE_SYNC(1)) dut_a (.clk(clk), .clr(clr), .bus(ifa));
  serial_word_deser #(.WIDTH(4), .REQUIRE_SYNC(0)) dut_b (.clk(clk), .clr(clr), .bus(ifb));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboards: every transfer on either output must match the oldest expected word.
  always @(negedge clk) begin
    logic [3:0] e;
    if (!clr && ifa.out_valid && ifa.out_ready) begin
      chk("mon_a_pending", 32'(qa.size() != 0), 32'd1);
      if (qa.size() != 0) begin
        e = qa.pop_front();
        chk("mon_a_q", 32'(ifa.q), 32'(e));
      end
    end
    if (!clr && ifb.out_valid && ifb.out_ready) begin
      chk("mon_b_pending", 32'(qb.size() != 0), 32'd1);
      if (qb.size() != 0) begin
        e = qb.pop_front();
        chk("mon_b_q", 32'(ifb.q), 32'(e));
      end
    end
  end

  task automatic stepa(input logic sv, input logic sy, input logic s, input logic lsb);
    ifa.sin_valid = sv;
    ifa.sync      = sy;
    ifa.sin       = s;
    ifa.lsb_first = lsb;
    @(posedge clk);
    #1;
    ifa.sin_valid = 1'b0;
    ifa.sync      = 1'b0;
  endtask

  task automatic stepb(input logic sv, input logic sy, input logic s);
    ifb.sin_valid = sv;
    ifb.sync      = sy;
    ifb.sin       = s;
    @(posedge clk);
    #1;
    ifb.sin_valid = 1'b0;
    ifb.sync      = 1'b0;
  endtask

  // Sends bits[3] first; lsb_first is inverted after the first bit to show it is only sampled there.
  task automatic send_a(input logic [3:0] bits, input logic lsb, input logic sy);
    for (int i = 3; i >= 0; i--)
      stepa(1'b1, sy && (i == 3), bits[i], (i == 3) ? lsb : ~lsb);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    clr   = 1'b1;
    {ifa.sin, ifa.sin_valid, ifa.sync, ifa.lsb_first, ifa.err_clr} = '0;
    {ifb.sin, ifb.sin_valid, ifb.sync, ifb.lsb_first, ifb.err_clr} = '0;
    ifa.out_ready = 1'b1;
    ifb.out_ready = 1'b1;
    #12 clr = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_q", 32'(ifa.q), 32'h0);
    chk("rst_vld", 32'(ifa.out_valid), 32'd0);
    chk("rst_busy", 32'(ifa.busy), 32'd0);
    chk("rst_flags", 32'({ifa.frame_err, ifa.overrun}), 32'd0);

    // 1: MSB-first 1,0,1,1
    qa.push_back(4'b1011);
    stepa(1'b1, 1'b1, 1'b1, 1'b0);
    chk("t1_busy", 32'(ifa.busy), 32'd1);
    stepa(1'b1, 1'b0, 1'b0, 1'b0);
    stepa(1'b1, 1'b0, 1'b1, 1'b0);
    stepa(1'b1, 1'b0, 1'b1, 1'b0);
    chk("t1_vld", 32'(ifa.out_valid), 32'd1);
    chk("t1_q", 32'(ifa.q), 32'hb);
    chk("t1_hunt", 32'(ifa.busy), 32'd0);
    stepa(1'b0, 1'b0, 1'b0, 1'b0);
    chk("t1_vld_drop", 32'(ifa.out_valid), 32'd0);
    chk("t1_q_kept", 32'(ifa.q), 32'hb);

    // 2: LSB-first 1,0,1,1, then again with a 3-cycle gap between bits 2 and 3
    qa.push_back(4'b1101);
    send_a(4'b1011, 1'b1, 1'b1);
    chk("t2_q", 32'(ifa.q), 32'hd);
    qa.push_back(4'b1101);
    stepa(1'b1, 1'b1, 1'b1, 1'b1);
    stepa(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) stepa(1'b0, 1'b0, 1'b0, 1'b0);
    chk("t2_gap_busy", 32'(ifa.busy), 32'd1);
    stepa(1'b1, 1'b0, 1'b1, 1'b0);
    stepa(1'b1, 1'b0, 1'b1, 1'b0);
    chk("t2_gap_q", 32'(ifa.q), 32'hd);
    chk("t2_gap_vld", 32'(ifa.out_valid), 32'd1);
    stepa(1'b0, 1'b0, 1'b0, 1'b0);

    // 3: overrun with consumer stalled
    ifa.out_ready = 1'b0;
    qa.push_back(4'b0110);
    send_a(4'b0110, 1'b0, 1'b1);
    chk("t3_q1", 32'(ifa.q), 32'h6);
    chk("t3_ovr0", 32'(ifa.overrun), 32'd0);
    send_a(4'b1001, 1'b0, 1'b1);
    chk("t3_q_held", 32'(ifa.q), 32'h6);
    chk("t3_ovr1", 32'(ifa.overrun), 32'd1);
    chk("t3_vld", 32'(ifa.out_valid), 32'd1);
    ifa.err_clr = 1'b1;
    stepa(1'b0, 1'b0, 1'b0, 1'b0);
    ifa.err_clr = 1'b0;
    chk("t3_ovr_clr", 32'(ifa.overrun), 32'd0);
    ifa.out_ready = 1'b1;
    stepa(1'b0, 1'b0, 1'b0, 1'b0);
    chk("t3_drained", 32'(ifa.out_valid), 32'd0);

    // 4: resync mid-word; err_clr on the same edge must lose to the set
    stepa(1'b1, 1'b1, 1'b1, 1'b0);
    stepa(1'b1, 1'b0, 1'b1, 1'b0);
    ifa.err_clr = 1'b1;
    stepa(1'b1, 1'b1, 1'b0, 1'b0);
    ifa.err_clr = 1'b0;
    chk("t4_frame", 32'(ifa.frame_err), 32'd1);
    qa.push_back(4'b0101);
    stepa(1'b1, 1'b0, 1'b1, 1'b0);
    stepa(1'b1, 1'b0, 1'b0, 1'b0);
    stepa(1'b1, 1'b0, 1'b1, 1'b0);
    chk("t4_q", 32'(ifa.q), 32'h5);
    send_a(4'b1111, 1'b0, 1'b0);
    chk("t4_nosync_busy", 32'(ifa.busy), 32'd0);
    chk("t4_nosync_vld", 32'(ifa.out_valid), 32'd0);
    chk("t4_nosync_q", 32'(ifa.q), 32'h5);
    ifa.err_clr = 1'b1;
    stepa(1'b0, 1'b0, 1'b0, 1'b0);
    ifa.err_clr = 1'b0;
    chk("t4_frame_clr", 32'(ifa.frame_err), 32'd0);

    // 5: async clear between edges, mid-word, with a held word on the output
    ifa.out_ready = 1'b0;
    send_a(4'b1110, 1'b0, 1'b1);
    chk("t5_held", 32'(ifa.out_valid), 32'd1);
    stepa(1'b1, 1'b1, 1'b1, 1'b0);
    stepa(1'b1, 1'b0, 1'b0, 1'b0);
    chk("t5_busy", 32'(ifa.busy), 32'd1);
    #2 clr = 1'b1;
    #1;
    chk("t5_q", 32'(ifa.q), 32'h0);
    chk("t5_vld", 32'(ifa.out_valid), 32'd0);
    chk("t5_busy0", 32'(ifa.busy), 32'd0);
    clr = 1'b0;
    ifa.out_ready = 1'b1;
    @(posedge clk);
    #1;
    qa.push_back(4'b0111);
    send_a(4'b0111, 1'b0, 1'b1);
    chk("t5_after_q", 32'(ifa.q), 32'h7);
    stepa(1'b0, 1'b0, 1'b0, 1'b0);

    // 6: back-to-back words after a single sync
    qb.push_back(4'b1100);
    stepb(1'b1, 1'b1, 1'b1);
    stepb(1'b1, 1'b0, 1'b1);
    stepb(1'b1, 1'b0, 1'b0);
    stepb(1'b1, 1'b0, 1'b0);
    chk("t6_q1", 32'(ifb.q), 32'hc);
    chk("t6_vld1", 32'(ifb.out_valid), 32'd1);
    chk("t6_busy", 32'(ifb.busy), 32'd1);
    qb.push_back(4'b0011);
    stepb(1'b1, 1'b0, 1'b0);
    stepb(1'b1, 1'b0, 1'b0);
    stepb(1'b1, 1'b0, 1'b1);
    stepb(1'b1, 1'b0, 1'b1);
    chk("t6_q2", 32'(ifb.q), 32'h3);
    chk("t6_vld2", 32'(ifb.out_valid), 32'd1);
    stepb(1'b0, 1'b0, 1'b0);
    chk("t6_flags", 32'({ifb.frame_err, ifb.overrun}), 32'd0);
    chk("t6_still_recv", 32'(ifb.busy), 32'd1);

    chk("sb_a_empty", 32'(qa.size()), 32'd0);
    chk("sb_b_empty", 32'(qb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
